// File: rtl/usr_pkg.sv
// usr_pkg
// Shared constants for the universal shift register: width of the mode
// select and the four mode encodings.
package usr_pkg;

    localparam int USR_SEL_W = 2;

    localparam logic [USR_SEL_W-1:0] USR_HOLD = 2'b00;
    localparam logic [USR_SEL_W-1:0] USR_SHR  = 2'b01;
    localparam logic [USR_SEL_W-1:0] USR_SHL  = 2'b10;
    localparam logic [USR_SEL_W-1:0] USR_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell
// One bit of the universal shift register: a 4:1 mux feeding a D flop
// with synchronous active-low clear.
// Ports:
//   clk_i    clock, rising edge
//   clr_i    synchronous clear, active low
//   sel_i    mode select (hold / shift right / shift left / load)
//   left_i   neighbour on the MSB side, taken on a right shift
//   right_i  neighbour on the LSB side, taken on a left shift
//   par_i    parallel load bit
//   q_o      stored bit
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic [USR_SEL_W-1:0] sel_i,
    input  logic                 left_i,
    input  logic                 right_i,
    input  logic                 par_i,
    output logic                 q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (sel_i)
            USR_HOLD: q_d = q_q;
            USR_SHR:  q_d = left_i;
            USR_SHL:  q_d = right_i;
            USR_LOAD: q_d = par_i;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg_top.sv
// universal_shift_reg_top
// Loadable, bidirectionally shiftable register built from DATA_WIDTH bit
// cells. Mode is chosen every rising edge by sel_mux.
// Ports:
//   i_clk    clock, rising edge
//   clr      synchronous clear, active low, priority over all modes
//   in       parallel load data
//   sel_mux  00 hold, 01 shift right, 10 shift left, 11 load
//   sr       serial bit entering the MSB on a right shift
//   sl       serial bit entering the LSB on a left shift
//   q_out    register contents (straight from flops)
//   so_r     q_out[0], bit lost by the next right shift  (USR_SERIAL_OUT_EN)
//   so_l     q_out[MSB], bit lost by the next left shift (USR_SERIAL_OUT_EN)
// Configuration macro: USR_SERIAL_OUT_EN adds so_r / so_l.
module universal_shift_reg_top
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [USR_SEL_W-1:0]  sel_mux,
    input  logic                  sr,
    input  logic                  sl,
`ifdef USR_SERIAL_OUT_EN
    output logic                  so_r,
    output logic                  so_l,
`endif
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH-1:0] q_q;

    // Boundary cells take the serial inputs in place of a missing neighbour.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cell
        logic left_n;
        logic right_n;

        if (i == DATA_WIDTH-1) begin : g_msb
            assign left_n = sr;
        end else begin : g_mid_l
            assign left_n = q_q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign right_n = sl;
        end else begin : g_mid_r
            assign right_n = q_q[i-1];
        end

        usr_bit_cell u_cell (
            .clk_i   (i_clk),
            .clr_i   (clr),
            .sel_i   (sel_mux),
            .left_i  (left_n),
            .right_i (right_n),
            .par_i   (in[i]),
            .q_o     (q_q[i])
        );
    end

    assign q_out = q_q;

`ifdef USR_SERIAL_OUT_EN
    assign so_r = q_q[0];
    assign so_l = q_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_universal_shift_reg_top.sv
module tb_universal_shift_reg_top;

    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic [W-1:0] in_d;
    logic [1:0]   sel;
    logic         sr;
    logic         sl;
    logic [W-1:0] q_out;
`ifdef USR_SERIAL_OUT_EN
    logic         so_r;
    logic         so_l;
`endif

    int total = 0;
    int bad   = 0;

    universal_shift_reg_top #(.DATA_WIDTH(W)) dut (
        .i_clk   (clk),
        .clr     (clr),
        .in      (in_d),
        .sel_mux (sel),
        .sr      (sr),
        .sl      (sl),
`ifdef USR_SERIAL_OUT_EN
        .so_r    (so_r),
        .so_l    (so_l),
`endif
        .q_out   (q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         clr;
        logic [1:0]   sel;
        logic [W-1:0] din;
        logic         sr;
        logic         sl;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [W-1:0] exp);
        total++;
        if (q_out !== exp) begin
            bad++;
            $display("FAIL %s: q_out=%h expected=%h", name, q_out, exp);
        end
`ifdef USR_SERIAL_OUT_EN
        total++;
        if (so_r !== exp[0] || so_l !== exp[W-1]) begin
            bad++;
            $display("FAIL %s_so: so_r=%b so_l=%b expected so_r=%b so_l=%b",
                     name, so_r, so_l, exp[0], exp[W-1]);
        end
`endif
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic c, input logic [1:0] s, input logic [W-1:0] d,
                        input logic r, input logic l);
        @(negedge clk);
        clr  = c;
        sel  = s;
        in_d = d;
        sr   = r;
        sl   = l;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model(input logic c, input logic [1:0] s,
                                           input logic [W-1:0] d, input logic r,
                                           input logic l, input logic [W-1:0] q);
        if (!c) return '0;
        case (s)
            2'b00:   return q;
            2'b01:   return {r, q[W-1:1]};
            2'b10:   return {q[W-2:0], l};
            default: return d;
        endcase
    endfunction

    initial begin
        logic [W-1:0] q_m;
        logic         rc;
        logic [1:0]   rs;
        logic [W-1:0] rd;
        logic         rr;
        logic         rl;

        clr = 1'b1; sel = 2'b00; in_d = '0; sr = 1'b0; sl = 1'b0;

        vecs[0]  = '{"rst1",   1'b0, 2'b11, 4'hF, 1'b1, 1'b1, 4'h0};
        vecs[1]  = '{"rst2",   1'b0, 2'b11, 4'hF, 1'b1, 1'b1, 4'h0};
        vecs[2]  = '{"loadF",  1'b1, 2'b11, 4'hF, 1'b0, 1'b0, 4'hF};
        vecs[3]  = '{"loadA",  1'b1, 2'b11, 4'hA, 1'b0, 1'b0, 4'hA};
        vecs[4]  = '{"hold1",  1'b1, 2'b00, 4'h3, 1'b1, 1'b1, 4'hA};
        vecs[5]  = '{"hold2",  1'b1, 2'b00, 4'h5, 1'b0, 1'b1, 4'hA};
        vecs[6]  = '{"hold3",  1'b1, 2'b00, 4'hF, 1'b1, 1'b0, 4'hA};
        vecs[7]  = '{"shr1",   1'b1, 2'b01, 4'h0, 1'b1, 1'b0, 4'hD};
        vecs[8]  = '{"shr0",   1'b1, 2'b01, 4'hF, 1'b0, 1'b1, 4'h6};
        vecs[9]  = '{"shr1b",  1'b1, 2'b01, 4'h0, 1'b1, 1'b0, 4'hB};
        vecs[10] = '{"load5",  1'b1, 2'b11, 4'h5, 1'b0, 1'b0, 4'h5};
        vecs[11] = '{"shl1",   1'b1, 2'b10, 4'h0, 1'b0, 1'b1, 4'hB};
        vecs[12] = '{"shl1b",  1'b1, 2'b10, 4'hF, 1'b1, 1'b1, 4'h7};
        vecs[13] = '{"shl0",   1'b1, 2'b10, 4'h0, 1'b1, 1'b0, 4'hE};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].clr, vecs[i].sel, vecs[i].din, vecs[i].sr, vecs[i].sl);
            check(vecs[i].name, vecs[i].exp);
        end

        // Inter-edge glitches: sel/in toggle between edges, 00 at each edge.
        step(1'b1, 2'b11, 4'h3, 1'b0, 1'b0);
        check("pre_glitch_load", 4'h3);
        for (int i = 0; i < 3; i++) begin
            sel = 2'b11; in_d = 4'hC; sr = 1'b1; sl = 1'b1;
            #2;
            sel = 2'b01;
            #1;
            sel = 2'b10; in_d = 4'h9;
            @(negedge clk);
            sel = 2'b00; in_d = 4'h0;
            @(posedge clk);
            #1;
            check("glitch_hold", 4'h3);
        end

        // Reset in the middle of a shift-right run, then restart from zero.
        step(1'b1, 2'b11, 4'hF, 1'b0, 1'b0);
        check("mid_load", 4'hF);
        step(1'b1, 2'b01, 4'h0, 1'b1, 1'b0);
        check("mid_shr1", 4'hF);
        step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
        check("mid_shr0", 4'h7);
        step(1'b0, 2'b01, 4'hF, 1'b1, 1'b1);
        check("mid_rst", 4'h0);
        step(1'b1, 2'b01, 4'hF, 1'b1, 1'b1);
        check("post_rst_shr1", 4'h8);
        step(1'b1, 2'b01, 4'hF, 1'b0, 1'b1);
        check("post_rst_shr0", 4'h4);

        // Randomized run against the reference model.
        q_m = 4'h4;
        for (int i = 0; i < 40; i++) begin
            rc = ($urandom_range(0, 9) != 0);
            rs = 2'($urandom_range(0, 3));
            rd = W'($urandom_range(0, 15));
            rr = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            q_m = model(rc, rs, rd, rr, rl, q_m);
            step(rc, rs, rd, rr, rl);
            check("rand", q_m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
